// File: rtl/input_conditioner.sv
// Synchronise, debounce and edge-detect one asynchronous bit.
// Edge counter built only when INPUT_COND_EDGE_COUNT_EN is defined.
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dat_in,
  input  logic             clr_cnt,
  output logic             dat_stable,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] edge_count,
  output logic             cnt_sat
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW,
    TO_HIGH,
    HIGH,
    TO_LOW
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], dat_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  state_t          state_q, state_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            stable_q, stable_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= LOW;
      dcnt_q   <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    unique case (state_q)
      LOW: begin
        if (s) begin
          state_d = TO_HIGH;
          dcnt_d  = DW'(1);
        end
      end
      TO_HIGH: begin
        if (!s) begin
          state_d = LOW;
          dcnt_d  = '0;
        end else if (dcnt_q == DLAST) begin
          state_d  = HIGH;
          dcnt_d   = '0;
          stable_d = 1'b1;
          rise_d   = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      HIGH: begin
        if (!s) begin
          state_d = TO_LOW;
          dcnt_d  = DW'(1);
        end
      end
      TO_LOW: begin
        if (s) begin
          state_d = HIGH;
          dcnt_d  = '0;
        end else if (dcnt_q == DLAST) begin
          state_d  = LOW;
          dcnt_d   = '0;
          stable_d = 1'b0;
          fall_d   = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
    endcase
  end

  assign dat_stable = stable_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

`ifdef INPUT_COND_EDGE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  // A clear coincident with a rise keeps that rise as the first count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = CNT_W'(rise_q);
    end else if (rise_q && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    sat_d = &cnt_d;
  end

  assign edge_count = cnt_q;
  assign cnt_sat    = sat_q;
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign edge_count = '0;
  assign cnt_sat    = 1'b0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: default instance plus a
// small CNT_W=4 / DEBOUNCE_CYCLES=4 instance for saturation.
module tb_input_conditioner;

  typedef struct {
    bit rise;
    int cyc;
    int cnt;
    bit sat;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, din_a, clr_a;
  logic        st_a, ri_a, fa_a, sat_a;
  logic [15:0] cnt_a;

  logic        rst_b, din_b, clr_b;
  logic        st_b, ri_b, fa_b, sat_b;
  logic [3:0]  cnt_b;

  input_conditioner u_a (
    .clk        (clk),
    .reset      (rst_a),
    .dat_in     (din_a),
    .clr_cnt    (clr_a),
    .dat_stable (st_a),
    .rise_pulse (ri_a),
    .fall_pulse (fa_a),
    .edge_count (cnt_a),
    .cnt_sat    (sat_a)
  );

  input_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (4)
  ) u_b (
    .clk        (clk),
    .reset      (rst_b),
    .dat_in     (din_b),
    .clr_cnt    (clr_b),
    .dat_stable (st_b),
    .rise_pulse (ri_b),
    .fall_pulse (fa_b),
    .edge_count (cnt_b),
    .cnt_sat    (sat_b)
  );

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  ev_t qa[$];
  ev_t qb[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ec(int x);
`ifdef INPUT_COND_EDGE_COUNT_EN
    return x;
`else
    return 0 * x;
`endif
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic exp_a(bit r, int cnt, bit sat);
    ev_t e;
    e.rise = r;
    e.cyc  = cyc + 18;
    e.cnt  = ec(cnt);
    e.sat  = (ec(1) == 1) ? sat : 1'b0;
    qa.push_back(e);
  endtask

  task automatic exp_b(bit r, int cnt, bit sat);
    ev_t e;
    e.rise = r;
    e.cyc  = cyc + 6;
    e.cnt  = ec(cnt);
    e.sat  = (ec(1) == 1) ? sat : 1'b0;
    qb.push_back(e);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (ri_a || fa_a) begin
      ev_t e;
      chk("a_both_pulses", int'(ri_a && fa_a), 0);
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_pulse rise=%0d fall=%0d cyc %0d",
                 ri_a, fa_a, cyc);
      end else begin
        e = qa.pop_front();
        if (e.rise != ri_a || e.cyc != cyc) begin
          errors++;
          $display("FAIL a_pulse got rise=%0d cyc=%0d want rise=%0d cyc=%0d",
                   ri_a, cyc, e.rise, e.cyc);
        end
        chk("a_stable_at_pulse", int'(st_a), int'(e.rise));
        chk("a_count_at_pulse", int'(cnt_a), e.cnt);
        chk("a_sat_at_pulse", int'(sat_a), int'(e.sat));
      end
    end
  end

  always @(negedge clk) begin
    if (ri_b || fa_b) begin
      ev_t e;
      chk("b_both_pulses", int'(ri_b && fa_b), 0);
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_pulse rise=%0d fall=%0d cyc %0d",
                 ri_b, fa_b, cyc);
      end else begin
        e = qb.pop_front();
        if (e.rise != ri_b || e.cyc != cyc) begin
          errors++;
          $display("FAIL b_pulse got rise=%0d cyc=%0d want rise=%0d cyc=%0d",
                   ri_b, cyc, e.rise, e.cyc);
        end
        chk("b_stable_at_pulse", int'(st_b), int'(e.rise));
        chk("b_count_at_pulse", int'(cnt_b), e.cnt);
        chk("b_sat_at_pulse", int'(sat_b), int'(e.sat));
      end
    end
  end

  task automatic chk_a_zero(string nm);
    chk({nm, "_stable"}, int'(st_a), 0);
    chk({nm, "_rise"}, int'(ri_a), 0);
    chk({nm, "_fall"}, int'(fa_a), 0);
    chk({nm, "_count"}, int'(cnt_a), 0);
    chk({nm, "_sat"}, int'(sat_a), 0);
  endtask

  initial begin
    rst_a = 1'b1; din_a = 1'b0; clr_a = 1'b0;
    rst_b = 1'b1; din_b = 1'b0; clr_b = 1'b0;
    tick(3);
    chk_a_zero("reset");
    chk("b_reset_count", int'(cnt_b), 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick(3);

    // glitch: high for 10 cycles only
    din_a = 1'b1;
    tick(10);
    din_a = 1'b0;
    tick(30);
    chk("glitch_stable", int'(st_a), 0);
    chk("glitch_count", int'(cnt_a), 0);

    // clean rise
    din_a = 1'b1;
    exp_a(1'b1, 0, 1'b0);
    tick(17);
    chk("rise_early_stable", int'(st_a), 0);
    tick(6);
    chk("rise_stable", int'(st_a), 1);
    chk("rise_count", int'(cnt_a), ec(1));

    // fall
    din_a = 1'b0;
    exp_a(1'b0, 1, 1'b0);
    tick(17);
    chk("fall_early_stable", int'(st_a), 1);
    tick(6);
    chk("fall_stable", int'(st_a), 0);
    chk("fall_count", int'(cnt_a), ec(1));

    // second rise
    din_a = 1'b1;
    exp_a(1'b1, 1, 1'b0);
    tick(25);
    chk("rise2_count", int'(cnt_a), ec(2));

    // async reset mid-run with random input
    #2 rst_a = 1'b1;
    #1 chk_a_zero("async_reset");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      din_a = 1'($urandom_range(0, 1));
      chk_a_zero("reset_hold");
    end
    din_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b0;
    tick(5);

    // reset at edge 8 of a debounce, then requalify
    din_a = 1'b1;
    tick(8);
    rst_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst8_stable", int'(st_a), 0);
      chk("rst8_rise", int'(ri_a), 0);
    end
    rst_a = 1'b0;
    exp_a(1'b1, 0, 1'b0);
    tick(17);
    chk("rst8_early_stable", int'(st_a), 0);
    tick(8);
    chk("rst8_count", int'(cnt_a), ec(1));

    // clear alone
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    @(negedge clk);
    chk("clr_alone_count", int'(cnt_a), 0);

    // saturation on the small instance
    for (int i = 0; i < 15; i++) begin
      din_b = 1'b1;
      exp_b(1'b1, i, 1'b0);
      tick(8);
      din_b = 1'b0;
      exp_b(1'b0, i + 1, (i == 14));
      tick(8);
    end
    chk("b_sat_count", int'(cnt_b), ec(15));
    chk("b_sat_flag", int'(sat_b), ec(1));
    din_b = 1'b1;
    exp_b(1'b1, 15, 1'b1);
    tick(8);
    din_b = 1'b0;
    exp_b(1'b0, 15, 1'b1);
    tick(8);
    chk("b_hold_count", int'(cnt_b), ec(15));

    // clear coincident with rise_pulse
    din_b = 1'b1;
    exp_b(1'b1, 15, 1'b1);
    tick(6);
    chk("b_clr_rise_visible", int'(ri_b), 1);
    clr_b = 1'b1;
    @(negedge clk);
    clr_b = 1'b0;
    chk("b_clr_rise_count", int'(cnt_b), ec(1));
    chk("b_clr_rise_sat", int'(sat_b), 0);
    tick(1);
    din_b = 1'b0;
    exp_b(1'b0, 1, 1'b0);
    tick(8);

    tick(5);
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
